// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the unified-RAM arbiter: access sizes, FSM states
// and the alignment rule used to reject D-side requests.
package riscv_mem_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_X = 2'd3;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_e;

    // Illegal size or an address that is not naturally aligned for the size.
    function automatic logic d_access_bad(input logic [1:0] size, input logic [1:0] offs);
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = offs[0];
            SIZE_W:  bad = (offs != 2'd0);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational lane merge for sub-word stores: overlays the right-aligned
// store data onto the old RAM word at the addressed byte/half lane.
module store_merge
    import riscv_mem_pkg::*;
(
    input  logic [31:0] old_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  offs_i,
    output logic [31:0] merged_o
);

    logic [31:0] lane_mask_s;
    logic [31:0] shifted_s;

    // Build the lane mask for the size, then move mask and data to the target lane.
    always_comb begin
        case (size_i)
            SIZE_B:  lane_mask_s = 32'h0000_00FF << {offs_i, 3'b000};
            SIZE_H:  lane_mask_s = 32'h0000_FFFF << {offs_i, 3'b000};
            default: lane_mask_s = 32'hFFFF_FFFF;
        endcase
        shifted_s = wdata_i << {offs_i, 3'b000};
        merged_o  = (old_i & ~lane_mask_s) | (shifted_s & lane_mask_s);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store unit:
// D priority with I starvation override, RMW for sub-word stores, registered responses.
module mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          i_req_i,
    input  logic [AW-1:0] i_addr_i,
    output logic          i_gnt_o,
    output logic          i_rvalid_o,
    output logic [DW-1:0] i_rdata_o,
    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [1:0]    d_size_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [DW-1:0] d_wdata_i,
    output logic          d_gnt_o,
    output logic          d_rvalid_o,
    output logic [DW-1:0] d_rdata_o,
    output logic          d_err_o,
    output logic          ram_we_o,
    output logic [AW-1:0] ram_a_o,
    output logic [DW-1:0] ram_wd_o,
    input  logic [DW-1:0] ram_rd_i
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    state_e          state_q;
    logic [SW-1:0]   starve_q;
    logic [AW-1:0]   rmw_addr_q;
    logic [DW-1:0]   rmw_data_q;
    logic            i_rvalid_q;
    logic [DW-1:0]   i_rdata_q;
    logic            d_rvalid_q;
    logic [DW-1:0]   d_rdata_q;
    logic            d_err_q;

    logic            idle_s;
    logic            starve_full_s;
    logic            d_win_s;
    logic            i_win_s;
    logic            d_bad_s;
    logic            d_word_st_s;
    logic [SW-1:0]   starve_d;
    logic [AW-1:0]   d_word_addr_s;
    logic [DW-1:0]   shifted_s;
    logic [DW-1:0]   load_data_s;
    logic [DW-1:0]   merged_s;

    store_merge u_merge (
        .old_i    (ram_rd_i),
        .wdata_i  (d_wdata_i),
        .size_i   (d_size_i),
        .offs_i   (d_addr_i[1:0]),
        .merged_o (merged_s)
    );

    // Arbitration: grants only in IDLE outside reset, D wins unless I is starved.
    always_comb begin
        idle_s        = (state_q == IDLE) && !rst_i;
        starve_full_s = (starve_q == SW'(STARVE_MAX));
        d_win_s       = idle_s && d_req_i && !(i_req_i && starve_full_s);
        i_win_s       = idle_s && i_req_i && !d_win_s;
        d_bad_s       = d_access_bad(d_size_i, d_addr_i[1:0]);
        d_word_st_s   = d_we_i && !d_bad_s && (d_size_i == SIZE_W);
        d_word_addr_s = d_addr_i & ~AW'(3);
        if (i_req_i && !i_win_s) begin
            starve_d = starve_full_s ? starve_q : starve_q + SW'(1);
        end else begin
            starve_d = SW'(0);
        end
    end

    // Load data: move the addressed lane down to bit 0 and zero-extend to the size.
    always_comb begin
        shifted_s = ram_rd_i >> {d_addr_i[1:0], 3'b000};
        case (d_size_i)
            SIZE_B:  load_data_s = DW'(shifted_s[7:0]);
            SIZE_H:  load_data_s = DW'(shifted_s[15:0]);
            default: load_data_s = shifted_s;
        endcase
    end

    // RAM port mux: pending merge write first, then the cycle's winner.
    always_comb begin
        ram_we_o = 1'b0;
        ram_a_o  = '0;
        ram_wd_o = '0;
        if (state_q == RMW_WR) begin
            ram_we_o = 1'b1;
            ram_a_o  = rmw_addr_q;
            ram_wd_o = rmw_data_q;
        end else if (i_win_s) begin
            ram_a_o  = i_addr_i & ~AW'(3);
        end else if (d_win_s && !d_bad_s) begin
            ram_a_o = d_word_addr_s;
            if (d_word_st_s) begin
                ram_we_o = 1'b1;
                ram_wd_o = d_wdata_i;
            end else begin
                ram_wd_o = '0;
            end
        end else begin
            ram_a_o = '0;
        end
    end

    // FSM, starvation counter and response registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            rmw_addr_q <= '0;
            rmw_data_q <= '0;
            i_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rvalid_q <= 1'b0;
            d_rdata_q  <= '0;
            d_err_q    <= 1'b0;
        end else begin
            starve_q   <= starve_d;
            i_rvalid_q <= i_win_s;
            if (i_win_s) begin
                i_rdata_q <= ram_rd_i;
            end
            d_rvalid_q <= 1'b0;
            d_err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (d_win_s) begin
                        if (d_bad_s) begin
                            d_rvalid_q <= 1'b1;
                            d_err_q    <= 1'b1;
                            d_rdata_q  <= '0;
                        end else if (!d_we_i) begin
                            d_rvalid_q <= 1'b1;
                            d_rdata_q  <= load_data_s;
                        end else if (d_word_st_s) begin
                            d_rvalid_q <= 1'b1;
                            d_rdata_q  <= '0;
                        end else begin
                            rmw_addr_q <= d_word_addr_s;
                            rmw_data_q <= merged_s;
                            state_q    <= RMW_WR;
                        end
                    end
                end
                RMW_WR: begin
                    d_rvalid_q <= 1'b1;
                    d_rdata_q  <= '0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign i_gnt_o    = i_win_s;
    assign d_gnt_o    = d_win_s;
    assign i_rvalid_o = i_rvalid_q;
    assign i_rdata_o  = i_rdata_q;
    assign d_rvalid_o = d_rvalid_q;
    assign d_rdata_o  = d_rdata_q;
    assign d_err_o    = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a word-array RAM and
// a transaction-level reference model (shadow memory, starvation count, due cycles).
module tb_mem_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        ram_we;
    logic [31:0] ram_a;
    logic [31:0] ram_wd;
    logic [31:0] ram_rd;

    logic [31:0] mem    [64];
    logic [31:0] shadow [64];
    logic        pre_we;
    logic [5:0]  pre_a;
    logic [31:0] pre_d;

    int tests = 0;
    int fails = 0;

    mem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(STARVE_MAX)) dut (
        .clk_i(clk), .rst_i(rst),
        .i_req_i(i_req), .i_addr_i(i_addr), .i_gnt_o(i_gnt),
        .i_rvalid_o(i_rvalid), .i_rdata_o(i_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_size_i(d_size), .d_addr_i(d_addr),
        .d_wdata_i(d_wdata), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid),
        .d_rdata_o(d_rdata), .d_err_o(d_err),
        .ram_we_o(ram_we), .ram_a_o(ram_a), .ram_wd_o(ram_wd), .ram_rd_i(ram_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ram_rd = mem[ram_a[7:2]];

    always @(posedge clk) begin
        if (ram_we) mem[ram_a[7:2]] <= ram_wd;
        else if (pre_we) mem[pre_a] <= pre_d;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pre_we = 1'b1;
        pre_a  = a[7:2];
        pre_d  = d;
        cyc();
        pre_we = 1'b0;
        shadow[a[7:2]] = d;
    endtask

    // Byte-by-byte overlay of a sub-word store, as a memory would see it.
    function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] size, input logic [1:0] off);
        logic [31:0] r;
        int nb;
        r  = old;
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        for (int j = 0; j < 4; j++) begin
            if (j >= off && j < off + nb) r[j*8 +: 8] = wd[(j-off)*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] off);
        logic [31:0] v;
        v = word / (32'd1 << (8 * off));
        if (size == 2'd0) v = v % 32'd256;
        else if (size == 2'd1) v = v % 32'd65536;
        return v;
    endfunction

    int          c;
    int          starve;
    bit          busy, new_busy, exp_i, exp_d, i_got, d_got, bad, exp_we;
    int          i_due, d_due;
    logic [31:0] i_exp, d_exp, w;
    bit          d_exp_err;

    initial begin
        rst = 1'b1; i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
        d_size = 2'd0; d_addr = 32'h0; d_wdata = 32'h0; pre_we = 1'b0; pre_a = 6'd0; pre_d = 32'h0;
        for (int k = 0; k < 64; k++) preload(32'(k) << 2, $urandom);

        // Reset state
        @(negedge clk);
        check("rst_i_gnt", i_gnt, 1'b0);    check("rst_d_gnt", d_gnt, 1'b0);
        check("rst_i_rvalid", i_rvalid, 1'b0); check("rst_d_rvalid", d_rvalid, 1'b0);
        check("rst_d_err", d_err, 1'b0);    check("rst_ram_we", ram_we, 1'b0);
        check("rst_ram_a", ram_a, 32'h0);   check("rst_ram_wd", ram_wd, 32'h0);
        check("rst_i_rdata", i_rdata, 32'h0); check("rst_d_rdata", d_rdata, 32'h0);
        cyc(); rst = 1'b0;

        // 1: lone fetch
        preload(32'h10, 32'hDEADBEEF);
        i_req = 1'b1; i_addr = 32'h10;
        @(negedge clk);
        check("t1_i_gnt", i_gnt, 1'b1); check("t1_ram_a", ram_a, 32'h10); check("t1_d_gnt", d_gnt, 1'b0);
        cyc(); i_req = 1'b0;
        @(negedge clk);
        check("t1_i_rvalid", i_rvalid, 1'b1); check("t1_i_rdata", i_rdata, 32'hDEADBEEF);

        // 2: D priority, I forced after STARVE_MAX losses
        cyc();
        i_req = 1'b1; i_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 32'h44;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("t2_d_gnt_c%0d", k), d_gnt, (k != 4));
            check($sformatf("t2_i_gnt_c%0d", k), i_gnt, (k == 4));
            cyc();
        end
        i_req = 1'b0; d_req = 1'b0;
        cyc();

        // 3: byte store via RMW, then word load sees merged data
        preload(32'h20, 32'h11223344);
        d_req = 1'b1; d_we = 1'b1; d_size = 2'd0; d_addr = 32'h21; d_wdata = 32'h123456AA;
        @(negedge clk);
        check("t3_d_gnt", d_gnt, 1'b1); check("t3_we_c0", ram_we, 1'b0);
        cyc(); d_req = 1'b0;
        shadow[8] = ref_store(shadow[8], 32'h123456AA, 2'd0, 2'd1);
        @(negedge clk);
        check("t3_we_c1", ram_we, 1'b1); check("t3_ram_a", ram_a, 32'h20);
        check("t3_ram_wd", ram_wd, 32'h1122AA44); check("t3_no_gnt", d_gnt, 1'b0);
        check("t3_no_ack_c1", d_rvalid, 1'b0);
        cyc();
        d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 32'h20;
        @(negedge clk);
        check("t3_ack", d_rvalid, 1'b1); check("t3_ack_err", d_err, 1'b0);
        check("t3_ack_rdata", d_rdata, 32'h0); check("t3_we_c2", ram_we, 1'b0);
        check("t3_ld_gnt", d_gnt, 1'b1);
        cyc(); d_req = 1'b0;
        @(negedge clk);
        check("t3_ld_rvalid", d_rvalid, 1'b1); check("t3_ld_rdata", d_rdata, 32'h1122AA44);

        // 4: half load, then misaligned half store
        cyc();
        d_req = 1'b1; d_we = 1'b0; d_size = 2'd1; d_addr = 32'h22;
        @(negedge clk);
        check("t4_ld_gnt", d_gnt, 1'b1);
        cyc();
        d_we = 1'b1; d_addr = 32'h23; d_wdata = 32'h0000BEEF;
        @(negedge clk);
        check("t4_ld_rdata", d_rdata, 32'h00001122); check("t4_ld_rvalid", d_rvalid, 1'b1);
        check("t4_st_gnt", d_gnt, 1'b1); check("t4_we_a", ram_we, 1'b0);
        cyc(); d_req = 1'b0;
        @(negedge clk);
        check("t4_err_rvalid", d_rvalid, 1'b1); check("t4_err", d_err, 1'b1);
        check("t4_err_rdata", d_rdata, 32'h0); check("t4_we_b", ram_we, 1'b0);
        check("t4_mem", mem[8], 32'h1122AA44);

        // 5: I blocked during merge write, granted right after
        cyc();
        d_req = 1'b1; d_we = 1'b1; d_size = 2'd0; d_addr = 32'h32; d_wdata = 32'h5A;
        @(negedge clk);
        check("t5_d_gnt", d_gnt, 1'b1);
        cyc(); d_req = 1'b0; i_req = 1'b1; i_addr = 32'h50;
        shadow[12] = ref_store(shadow[12], 32'h5A, 2'd0, 2'd2);
        @(negedge clk);
        check("t5_rmw_we", ram_we, 1'b1); check("t5_i_blocked", i_gnt, 1'b0);
        cyc();
        @(negedge clk);
        check("t5_i_gnt", i_gnt, 1'b1); check("t5_d_ack", d_rvalid, 1'b1);
        cyc(); i_req = 1'b0;
        @(negedge clk);
        check("t5_i_rdata", i_rdata, shadow[20]); check("t5_i_rvalid", i_rvalid, 1'b1);
        check("t5_mem", mem[12], shadow[12]);

        // 6: reset in the middle of a merge
        cyc();
        d_req = 1'b1; d_we = 1'b1; d_size = 2'd0; d_addr = 32'h60; d_wdata = 32'h77;
        @(negedge clk);
        check("t6_d_gnt", d_gnt, 1'b1);
        cyc(); d_req = 1'b0;
        check("t6_rmw_we", ram_we, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("t6_we", ram_we, 1'b0); check("t6_ram_a", ram_a, 32'h0);
        check("t6_ram_wd", ram_wd, 32'h0); check("t6_d_rvalid", d_rvalid, 1'b0);
        check("t6_i_rvalid", i_rvalid, 1'b0); check("t6_d_rdata", d_rdata, 32'h0);
        cyc(); cyc();
        check("t6_mem", mem[24], shadow[24]);
        rst = 1'b0;
        @(negedge clk);
        check("t6_no_ack", d_rvalid, 1'b0); check("t6_we_after", ram_we, 1'b0);

        // Randomized traffic against the reference model
        starve = 0; busy = 1'b0; i_due = -1; d_due = -1; i_got = 1'b0; d_got = 1'b0;
        i_exp = 32'h0; d_exp = 32'h0; d_exp_err = 1'b0;
        for (c = 0; c < 1500; c++) begin
            cyc();
            if (!i_req || i_got) begin
                i_req  = 1'($urandom_range(0, 1));
                i_addr = 32'($urandom_range(0, 63)) << 2;
            end
            if (!d_req || d_got) begin
                d_req   = 1'($urandom_range(0, 1));
                d_we    = 1'($urandom_range(0, 1));
                d_size  = 2'($urandom_range(0, 3));
                d_addr  = 32'($urandom_range(0, 255));
                d_wdata = $urandom;
            end
            @(negedge clk);
            check("r_i_rvalid", i_rvalid, (i_due == c));
            if (i_due == c) check("r_i_rdata", i_rdata, i_exp);
            check("r_d_rvalid", d_rvalid, (d_due == c));
            if (d_due == c) begin
                check("r_d_rdata", d_rdata, d_exp);
                check("r_d_err", d_err, d_exp_err);
            end
            exp_d = !busy && d_req && !(i_req && starve == STARVE_MAX);
            exp_i = !busy && i_req && !exp_d;
            check("r_d_gnt", d_gnt, exp_d);
            check("r_i_gnt", i_gnt, exp_i);
            bad = (d_size == 2'd3) || (d_size == 2'd1 && d_addr[0]) ||
                  (d_size == 2'd2 && d_addr[1:0] != 2'd0);
            exp_we = busy || (exp_d && d_we && !bad && d_size == 2'd2);
            check("r_ram_we", ram_we, exp_we);
            starve = (i_req && !exp_i) ? ((starve < STARVE_MAX) ? starve + 1 : STARVE_MAX) : 0;
            new_busy = 1'b0;
            if (exp_i) begin
                i_due = c + 1;
                i_exp = shadow[i_addr[7:2]];
            end
            if (exp_d) begin
                w = shadow[d_addr[7:2]];
                d_exp = 32'h0; d_exp_err = bad; d_due = c + 1;
                if (!bad && !d_we) begin
                    d_exp = ref_load(w, d_size, d_addr[1:0]);
                end else if (!bad) begin
                    shadow[d_addr[7:2]] = ref_store(w, d_wdata, d_size, d_addr[1:0]);
                    if (d_size != 2'd2) begin
                        d_due = c + 2;
                        new_busy = 1'b1;
                    end
                end
            end
            busy = new_busy; i_got = exp_i; d_got = exp_d;
        end
        i_req = 1'b0; d_req = 1'b0;
        cyc(); cyc(); cyc();
        for (int k = 0; k < 64; k += 7) check($sformatf("r_mem_%0d", k), mem[k], shadow[k]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
